fe_tobytes: RTL

Sequential canonical-encoding stage for Ed25519 field elements. It consumes a 10-limb signed radix-2^25.5 element, as produced by the squaring/multiply stages (e.g. fe_sq2 `h`). It fully reduces the element mod p = 2^255−19 and packs it into the 256-bit little-endian encoding used by point compression and signature output. One shared adder/shifter datapath walks the limbs one per cycle.

---
 rtl/fe_tobytes_pkg.sv | 32 +++
 rtl/fe_tobytes_if.sv | 13 +
 rtl/fe_limb_pack.sv | 23 ++
 rtl/fe_tobytes.sv | 139 +++++++++++++
 4 files changed

// File: rtl/fe_tobytes_pkg.sv
// Shared limb layout, state encoding and small arithmetic helpers for the
// field-element encoding stages.
package fe_pkg;

    localparam int NLIMB  = 10;
    localparam int LIMB_W = 32;
    localparam int ACC_W  = 64;

    localparam int LIMB_SHIFT  [NLIMB] = '{26, 25, 26, 25, 26, 25, 26, 25, 26, 25};
    localparam int LIMB_OFFSET [NLIMB] = '{0, 26, 51, 77, 102, 128, 153, 179, 204, 230};

    typedef logic signed [ACC_W-1:0] acc_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_QINIT,
        ST_QCHAIN,
        ST_FOLD,
        ST_CARRY,
        ST_PACK
    } fe_tb_state_t;

    function automatic logic [4:0] limb_shift(input logic [3:0] idx);
        return idx[0] ? 5'd25 : 5'd26;
    endfunction

    // 19*x as shifts and adds so no multiplier is inferred
    function automatic acc_t times19(input acc_t x);
        return (x <<< 4) + (x <<< 1) + x;
    endfunction

endpackage

// File: rtl/fe_tobytes_if.sv
// Request/result bundle between a field-element producer and the encoder.
interface fe_tobytes_if;

    logic                                     start;
    logic [fe_pkg::NLIMB*fe_pkg::LIMB_W-1:0]  f;
    logic [255:0]                             s;
    logic                                     busy;
    logic                                     done;

    modport master (output start, output f, input s, input busy, input done);
    modport slave  (input start, input f, output s, output busy, output done);

endinterface

// File: rtl/fe_limb_pack.sv
// Packs ten fully carried limbs into the 256-bit little-endian encoding.
module fe_limb_pack
    import fe_pkg::*;
(
    input  acc_t         limbs_i [NLIMB],
    output logic [255:0] s_o
);

    logic [255:0] term [NLIMB];

    for (genvar gi = 0; gi < NLIMB; gi++) begin : g_term
        localparam acc_t MASK = (acc_t'(1) <<< LIMB_SHIFT[gi]) - acc_t'(1);
        assign term[gi] = {192'd0, limbs_i[gi] & MASK} << LIMB_OFFSET[gi];
    end

    always_comb begin
        s_o = '0;
        for (int i = 0; i < NLIMB; i++) begin
            s_o = s_o | term[i];
        end
    end

endmodule

// File: rtl/fe_tobytes.sv
// Sequential canonical encoder: reduces a 10-limb element mod 2^255-19 with
// one adder/shifter walking the limbs, then packs it to 32 bytes.
module fe_tobytes
    import fe_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    fe_tobytes_if.slave  bus
);

    localparam acc_t Q_ROUND = acc_t'(64'sd16777216);

    fe_tb_state_t state_q;
    logic [3:0]   idx_q;
    acc_t         h_q [NLIMB];
    acc_t         q_q;
    logic [255:0] s_q;
    logic         busy_q;
    logic         done_q;

    acc_t         f_ext [NLIMB];
    acc_t         h_cur;
    acc_t         x19;
    acc_t         add_a;
    acc_t         add_b;
    acc_t         sum_d;
    acc_t         shr_d;
    acc_t         low_d;
    acc_t         low_mask;
    logic [4:0]   sh;
    logic [255:0] pack_s;

    for (genvar gi = 0; gi < NLIMB; gi++) begin : g_ext
        assign f_ext[gi] = acc_t'($signed(bus.f[gi*LIMB_W +: LIMB_W]));
    end

    // During CARRY the carry out of limb idx-1 rides in q_q and is added to
    // limb idx on the next step, so the same add/shift/mask serves every state.
    always_comb begin
        sh       = (state_q == ST_QINIT) ? 5'd25 : limb_shift(idx_q);
        h_cur    = h_q[idx_q];
        x19      = times19((state_q == ST_QINIT) ? h_q[NLIMB-1] : q_q);
        add_a    = h_cur;
        add_b    = q_q;
        case (state_q)
            ST_QINIT: begin
                add_a = x19;
                add_b = Q_ROUND;
            end
            ST_FOLD: begin
                add_a = h_q[0];
                add_b = x19;
            end
            default: begin
                add_a = h_cur;
                add_b = q_q;
            end
        endcase
        sum_d    = add_a + add_b;
        shr_d    = sum_d >>> sh;
        low_mask = (acc_t'(1) << sh) - acc_t'(1);
        low_d    = sum_d & low_mask;
    end

    fe_limb_pack u_pack (
        .limbs_i (h_q),
        .s_o     (pack_s)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            q_q     <= '0;
            s_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < NLIMB; i++) begin
                h_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        for (int i = 0; i < NLIMB; i++) begin
                            h_q[i] <= f_ext[i];
                        end
                        q_q     <= '0;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_QINIT;
                    end
                end
                ST_QINIT: begin
                    q_q     <= shr_d;
                    idx_q   <= '0;
                    state_q <= ST_QCHAIN;
                end
                ST_QCHAIN: begin
                    q_q <= shr_d;
                    if (idx_q == 4'd9) begin
                        idx_q   <= '0;
                        state_q <= ST_FOLD;
                    end else begin
                        idx_q <= idx_q + 4'd1;
                    end
                end
                ST_FOLD: begin
                    h_q[0]  <= sum_d;
                    q_q     <= '0;
                    state_q <= ST_CARRY;
                end
                ST_CARRY: begin
                    h_q[idx_q] <= low_d;
                    q_q        <= shr_d;
                    if (idx_q == 4'd9) begin
                        idx_q   <= '0;
                        state_q <= ST_PACK;
                    end else begin
                        idx_q <= idx_q + 4'd1;
                    end
                end
                ST_PACK: begin
                    s_q     <= pack_s;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.s    = s_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule
